// File: rtl/aec_expr_feeder.sv
// Host-side front-end for the AEC calculator: validates and buffers one '='-terminated
// expression, bursts it to AEC without gaps, then returns AEC's result or an error flag.
module aec_expr_feeder #(
    parameter int BUF_DEPTH = 64,
    parameter int MAX_WAIT  = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    input  logic [7:0]  s_data,
    output logic        s_ready,
    output logic        aec_ready,
    output logic [7:0]  aec_ascii,
    input  logic        aec_finish,
    input  logic [31:0] aec_result,
    output logic        m_valid,
    output logic [31:0] m_result,
    output logic        m_error,
    input  logic        m_ready
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [7:0] EQ = 8'h3D;

    typedef enum logic [2:0] {FILL, SEND, WAIT, DONE, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] wait_q, wait_d;
    logic [31:0]   m_result_q, m_result_d;
    logic          m_error_q, m_error_d;
    logic [7:0]    mem_q [BUF_DEPTH];
    logic          wr_en;
    logic          s_fire;
    logic          legal;
    logic          is_eq;

    function automatic logic is_legal(input logic [7:0] c);
        return (c >= 8'h30 && c <= 8'h39) || (c >= 8'h61 && c <= 8'h66) ||
               (c inside {8'h28, 8'h29, 8'h2A, 8'h2B, 8'h2D, 8'h3D});
    endfunction

    assign s_ready   = (state_q == FILL) || (state_q == DRAIN);
    assign s_fire    = s_valid && s_ready;
    assign legal     = is_legal(s_data);
    assign is_eq     = (s_data == EQ);
    assign aec_ready = (state_q == SEND) && (rd_ptr_q == '0);
    // AEC keeps sampling its input while computing, so '=' must stay parked there.
    assign aec_ascii = (state_q == SEND) ? mem_q[rd_ptr_q[AW-1:0]] : EQ;
    assign m_valid   = (state_q == DONE);
    assign m_result  = m_result_q;
    assign m_error   = m_error_q;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        wait_d     = wait_q;
        m_result_d = m_result_q;
        m_error_d  = m_error_q;
        wr_en      = 1'b0;
        case (state_q)
            FILL: if (s_fire) begin
                if (!legal) begin
                    state_d = DRAIN;
                end else if (is_eq) begin
                    if (wr_ptr_q == '0) begin
                        state_d    = DONE;
                        m_error_d  = 1'b1;
                        m_result_d = '0;
                    end else begin
                        // '=' sits at wr_ptr, so rd_ptr==wr_ptr marks the burst's last beat
                        wr_en    = 1'b1;
                        rd_ptr_d = '0;
                        state_d  = SEND;
                    end
                end else if (wr_ptr_q == PW'(BUF_DEPTH - 1)) begin
                    state_d = DRAIN;
                end else begin
                    wr_en    = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
            end
            SEND: begin
                if (rd_ptr_q == wr_ptr_q) begin
                    if (aec_finish) begin
                        m_result_d = aec_result;
                        m_error_d  = 1'b0;
                        state_d    = DONE;
                    end else begin
                        wait_d  = '0;
                        state_d = WAIT;
                    end
                end else begin
                    rd_ptr_d = rd_ptr_q + 1'b1;
                end
            end
            WAIT: begin
                if (aec_finish) begin
                    m_result_d = aec_result;
                    m_error_d  = 1'b0;
                    state_d    = DONE;
                end else if (wait_q == CW'(MAX_WAIT - 1)) begin
                    m_result_d = '0;
                    m_error_d  = 1'b1;
                    state_d    = DONE;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            DONE: if (m_ready) begin
                state_d    = FILL;
                wr_ptr_d   = '0;
                rd_ptr_d   = '0;
                m_error_d  = 1'b0;
                m_result_d = '0;
            end
            DRAIN: if (s_fire && is_eq) begin
                state_d    = DONE;
                m_error_d  = 1'b1;
                m_result_d = '0;
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FILL;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wait_q     <= '0;
            m_result_q <= '0;
            m_error_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            wait_q     <= wait_d;
            m_result_q <= m_result_d;
            m_error_q  <= m_error_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= s_data;
    end
endmodule

// File: tb/tb_aec_expr_feeder.sv
// Directed bench for aec_expr_feeder (BUF_DEPTH=8, MAX_WAIT=16) with a small AEC responder.
module tb_aec_expr_feeder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_ready;
    logic        aec_ready;
    logic [7:0]  aec_ascii;
    logic        aec_finish = 1'b0;
    logic [31:0] aec_result = 32'h0;
    logic        m_valid;
    logic [31:0] m_result;
    logic        m_error;
    logic        m_ready = 1'b0;

    int checks = 0;
    int failures = 0;

    // responder controls: fin_delay<0 never finishes, 0 finishes on the '=' beat
    int          fin_delay = 3;
    bit          stray = 1'b0;
    logic [31:0] resp_val = 32'h0;
    int          rdy_cnt = 0;
    logic [7:0]  burst_q[$];
    bit          in_burst = 1'b0;
    bit          pending = 1'b0;
    int          cd = 0;

    aec_expr_feeder #(.BUF_DEPTH(8), .MAX_WAIT(16)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .aec_ready(aec_ready), .aec_ascii(aec_ascii), .aec_finish(aec_finish),
        .aec_result(aec_result), .m_valid(m_valid), .m_result(m_result),
        .m_error(m_error), .m_ready(m_ready)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        aec_finish = 1'b0;
        if (!rst_n) begin
            in_burst = 1'b0;
            pending  = 1'b0;
        end else begin
            if (pending) begin
                cd--;
                if (cd == 0) begin
                    pending    = 1'b0;
                    aec_finish = 1'b1;
                    aec_result = resp_val;
                end
            end
            if (aec_ready) begin
                rdy_cnt++;
                in_burst = 1'b1;
                burst_q.delete();
                if (stray) begin
                    aec_finish = 1'b1;
                    aec_result = 32'hDEAD_BEEF;
                end
            end
            if (in_burst) begin
                burst_q.push_back(aec_ascii);
                if (aec_ascii == 8'h3D || burst_q.size() >= 20) begin
                    in_burst = 1'b0;
                    if (fin_delay == 0) begin
                        aec_finish = 1'b1;
                        aec_result = resp_val;
                    end else if (fin_delay > 0) begin
                        pending = 1'b1;
                        cd      = fin_delay;
                    end
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_burst(input string tag, input string exp);
        bit ok;
        string obs;
        obs = "";
        ok = (burst_q.size() == exp.len());
        for (int i = 0; i < burst_q.size(); i++) obs = $sformatf("%s%c", obs, burst_q[i]);
        if (ok) for (int i = 0; i < exp.len(); i++) if (burst_q[i] != exp[i]) ok = 1'b0;
        checks++;
        assert (ok === 1'b1) else begin
            failures++;
            $error("FAIL %s burst observed=\"%s\" expected=\"%s\"", tag, obs, exp);
        end
    endtask

    // called at a negedge; returns at the negedge after the transfer edge
    task automatic send_char(input logic [7:0] c);
        int t;
        t = 0;
        s_valid = 1'b1;
        s_data  = c;
        while (!s_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) chk("s_ready_timeout", {31'b0, s_ready}, 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_str(input string s, input bit gaps);
        for (int i = 0; i < s.len(); i++) begin
            if (gaps) begin
                s_valid = 1'b0;
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
            send_char(s[i]);
        end
    endtask

    task automatic get_result(input string tag, input logic [31:0] er, input logic ee);
        int t;
        t = 0;
        while (m_valid !== 1'b1 && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_valid"}, {31'b0, m_valid}, 32'd1);
        chk({tag, "_res"}, m_result, er);
        chk({tag, "_err"}, {31'b0, m_error}, {31'b0, ee});
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        chk({tag, "_clr"}, {31'b0, m_valid}, 32'd0);
        chk({tag, "_sready"}, {31'b0, s_ready}, 32'd1);
    endtask

    initial begin
        int r0;
        repeat (3) @(negedge clk);
        // reset values
        chk("rst_sready", {31'b0, s_ready}, 32'd1);
        chk("rst_aec_ready", {31'b0, aec_ready}, 32'd0);
        chk("rst_aec_ascii", {24'b0, aec_ascii}, 32'h3D);
        chk("rst_mvalid", {31'b0, m_valid}, 32'd0);
        chk("rst_mresult", m_result, 32'd0);
        chk("rst_merror", {31'b0, m_error}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: back-to-back, stray finish during burst must be ignored
        stray = 1'b1; fin_delay = 3; resp_val = 32'd11; r0 = rdy_cnt;
        send_str("3+4*2=", 1'b0);
        chk("t1_lat_ready", {31'b0, aec_ready}, 32'd1);
        chk("t1_first_char", {24'b0, aec_ascii}, 32'h33);
        @(negedge clk);
        chk("t1_ready_pulse", {31'b0, aec_ready}, 32'd0);
        get_result("t1", 32'd11, 1'b0);
        chk_burst("t1", "3+4*2=");
        chk("t1_rdy_cnt", rdy_cnt - r0, 32'd1);
        stray = 1'b0;

        // 2: host gaps, AEC burst still contiguous
        fin_delay = 5; resp_val = 32'd24;
        send_str("(a-2)*3=", 1'b1);
        chk("t2_first_char", {24'b0, aec_ascii}, 32'h28);
        get_result("t2", 32'd24, 1'b0);
        chk_burst("t2", "(a-2)*3=");
        chk("t2_hold_eq", {24'b0, aec_ascii}, 32'h3D);

        // 3: finish on the '=' beat, then empty expression
        fin_delay = 0; resp_val = 32'd7;
        send_str("7=", 1'b0);
        get_result("t3a", 32'd7, 1'b0);
        chk_burst("t3a", "7=");
        r0 = rdy_cnt; resp_val = 32'd99;
        send_str("=", 1'b0);
        get_result("t3b", 32'd0, 1'b1);
        chk("t3b_no_aec", rdy_cnt - r0, 32'd0);

        // 4: illegal characters drain to error; recovery afterwards
        fin_delay = 2; resp_val = 32'd55; r0 = rdy_cnt;
        send_str("1+G=", 1'b0);
        get_result("t4a", 32'd0, 1'b1);
        send_str("1 +1=", 1'b0);
        get_result("t4b", 32'd0, 1'b1);
        send_str("A=", 1'b0);
        get_result("t4c", 32'd0, 1'b1);
        chk("t4_no_aec", rdy_cnt - r0, 32'd0);
        resp_val = 32'd2;
        send_str("1+1=", 1'b1);
        get_result("t4d", 32'd2, 1'b0);

        // 5: BUF_DEPTH=8 overflow, then exact-fit expression
        r0 = rdy_cnt; resp_val = 32'd77;
        send_str("1+1+1+1+1=", 1'b0);
        get_result("t5a", 32'd0, 1'b1);
        chk("t5a_no_aec", rdy_cnt - r0, 32'd0);
        resp_val = 32'd10;
        send_str("f-5=", 1'b0);
        get_result("t5b", 32'd10, 1'b0);
        resp_val = 32'd4;
        send_str("1+1+1+1=", 1'b0);
        get_result("t5c", 32'd4, 1'b0);
        chk_burst("t5c", "1+1+1+1=");

        // 6a: result held while consumer stalls
        fin_delay = 2; resp_val = 32'd8;
        send_str("9-1=", 1'b0);
        while (m_valid !== 1'b1 && r0 < 100000) begin @(negedge clk); r0++; end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t6_hold_valid", {31'b0, m_valid}, 32'd1);
            chk("t6_hold_res", m_result, 32'd8);
            chk("t6_hold_sready", {31'b0, s_ready}, 32'd0);
        end
        get_result("t6a", 32'd8, 1'b0);

        // 6b: watchdog fires after exactly MAX_WAIT cycles in WAIT
        fin_delay = -1;
        send_str("1+2=", 1'b0);
        repeat (19) @(negedge clk);
        chk("t6_wd_early", {31'b0, m_valid}, 32'd0);
        @(negedge clk);
        chk("t6_wd_fire", {31'b0, m_valid}, 32'd1);
        get_result("t6b", 32'd0, 1'b1);

        // 6c: async reset mid-burst
        send_str("1+2+3=", 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_aec_ready", {31'b0, aec_ready}, 32'd0);
        chk("t6_rst_aec_ascii", {24'b0, aec_ascii}, 32'h3D);
        chk("t6_rst_sready", {31'b0, s_ready}, 32'd1);
        chk("t6_rst_mvalid", {31'b0, m_valid}, 32'd0);
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        fin_delay = 1; resp_val = 32'd6;
        send_str("2*3=", 1'b0);
        get_result("t6c", 32'd6, 1'b0);
        chk_burst("t6c", "2*3=");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
